// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bundle between the crossbar and its slaves.
//   AW: awaddr/awvalid/awready   W: wdata/wmask/wvalid/wready   B: bresp/bvalid/bready
//   AR: araddr/arvalid/arready   R: rdata/rresp/rvalid/rready
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport slave (
        input  awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_tx_lite.sv
// uart_tx_lite: AXI4-Lite slave that queues written bytes in a FIFO and sends them 8N1 on tx.
//   clk   - sole clock, all state on posedge
//   reset - asynchronous active-low reset
//   s     - AXI4-Lite slave; writes push wdata[7:0] when wmask[0], reads return status
//           status = {16'h0, count[7:0], 5'h0, busy, empty, full}
//   tx    - serial line, idle high, driven from a register
module uart_tx_lite #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    axi_lite_if.slave s,
    output logic      tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DIVISOR);
    localparam logic [BW-1:0] BAUD_MAX = BW'(DIVISOR - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    logic          aw_pend, w_pend, w_mask_q, bvalid_q, rvalid_q;
    logic [7:0]    w_data_q, data_now;
    logic [31:0]   rdata_q, status;
    logic          aw_hs, w_hs, ar_hs, commit, mask_now;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n, baud_done, load;
    logic          unused_ok;

    assign full   = count == FULL_CNT;
    assign empty  = count == '0;
    assign status = {16'h0, 8'(count), 5'h0, state != IDLE, empty, full};

    assign aw_hs = s.awvalid && !aw_pend && !bvalid_q;
    assign w_hs  = s.wvalid && !w_pend && !bvalid_q;
    assign ar_hs = s.arvalid && !rvalid_q;

    assign s.awready = !aw_pend && !bvalid_q;
    assign s.wready  = !w_pend && !bvalid_q;
    assign s.arready = !rvalid_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = 2'b00;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = 2'b00;
    assign tx        = tx_q;

    // A W beat arriving this cycle supplies its byte directly, so a same-cycle AW+W commits at once.
    assign mask_now = w_hs ? s.wmask[0] : w_mask_q;
    assign data_now = w_hs ? s.wdata[7:0] : w_data_q;
    assign commit   = (aw_pend || aw_hs) && (w_pend || w_hs) && !full;
    assign push     = commit && mask_now;

    // Address decoding is done by the crossbar; only the low byte lane carries data.
    assign unused_ok = ^{s.awaddr, s.araddr, s.wdata[31:8], s.wmask[3:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            w_mask_q <= 1'b0;
            w_data_q <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            aw_pend  <= !commit && (aw_pend || aw_hs);
            w_pend   <= !commit && (w_pend || w_hs);
            if (w_hs) begin
                w_mask_q <= s.wmask[0];
                w_data_q <= s.wdata[7:0];
            end
            bvalid_q <= commit || (bvalid_q && !s.bready);
            rvalid_q <= ar_hs || (rvalid_q && !s.rready);
            if (ar_hs)
                rdata_q <= status;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // A new frame is loaded from IDLE, or straight out of a finished STOP bit so frames abut.
    assign baud_done = baud == '0;
    assign load      = !empty && (state == IDLE || (state == STOP && baud_done));

    always_comb begin
        state_n = state;
        baud_n  = baud_done ? BAUD_MAX : baud - BW'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = load;
        if (load) begin
            state_n = START;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            baud_n  = BAUD_MAX;
        end else begin
            case (state)
                IDLE: begin
                    baud_n = '0;
                    tx_n   = 1'b1;
                end
                START: begin
                    if (baud_done) begin
                        state_n = DATA;
                        bit_n   = '0;
                        tx_n    = shift[0];
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        state_n = bit_idx == 3'd7 ? STOP : DATA;
                        bit_n   = bit_idx + 3'd1;
                        shift_n = shift >> 1;
                        tx_n    = bit_idx == 3'd7 ? 1'b1 : shift[1];
                    end
                end
                STOP: begin
                    if (baud_done)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_lite.sv
// tb_uart_tx_lite: directed bench for uart_tx_lite with DIVISOR=4, FIFO_DEPTH=16.
module tb_uart_tx_lite;
    localparam int D     = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
    int   vec = 0;
    int   err = 0;
    int   cyc = 0;

    axi_lite_if s_if ();

    uart_tx_lite #(.DIVISOR(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s_if),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_status(output logic rv, output logic [31:0] d, output logic [1:0] rr);
        s_if.arvalid = 1'b1;
        tick();
        s_if.arvalid = 1'b0;
        rv = s_if.rvalid;
        d  = s_if.rdata;
        rr = s_if.rresp;
        s_if.rready = 1'b1;
        tick();
        s_if.rready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [3:0] m, input logic brdy,
                            output int n, output logic ok, output logic [1:0] br);
        logic aw_acc, w_acc;
        s_if.awvalid = 1'b1;
        s_if.wvalid  = 1'b1;
        s_if.wdata   = {24'h0, d};
        s_if.wmask   = m;
        s_if.bready  = brdy;
        n  = 0;
        ok = 1'b0;
        br = 2'b11;
        while (!ok && n < 200) begin
            aw_acc = s_if.awvalid && s_if.awready;
            w_acc  = s_if.wvalid && s_if.wready;
            tick();
            n++;
            if (aw_acc) s_if.awvalid = 1'b0;
            if (w_acc) s_if.wvalid = 1'b0;
            if (s_if.bvalid === 1'b1) begin
                ok = 1'b1;
                br = s_if.bresp;
            end
        end
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
        if (ok && brdy) tick();
    endtask

    task automatic rx_frame(output logic got, output logic [7:0] b, output int t0, output logic fr_ok);
        int n = 0;
        got = 1'b0;
        b = '0;
        t0 = 0;
        fr_ok = 1'b0;
        while (tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (tx === 1'b0) begin
            got = 1'b1;
            t0 = cyc;
            repeat (D / 2) tick();
            fr_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (D) tick();
                b[i] = tx;
            end
            repeat (D) tick();
            fr_ok = fr_ok && (tx === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic rv;
        logic [31:0] d;
        logic [1:0] rr;
        reset = 1'b0;
        repeat (3) tick();
        vec++;
        if (tx !== 1'b1 || s_if.bvalid !== 1'b0 || s_if.rvalid !== 1'b0 || s_if.rdata !== 32'h0 ||
            s_if.bresp !== 2'b00 || s_if.rresp !== 2'b00) begin
            err++;
            $display("FAIL reset_outputs: tx=%b bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b, required 1 0 0 00000000 00 00",
                     tx, s_if.bvalid, s_if.rvalid, s_if.rdata, s_if.bresp, s_if.rresp);
        end
        reset = 1'b1;
        tick();
        vec++;
        if ({s_if.awready, s_if.wready, s_if.arready} !== 3'b111) begin
            err++;
            $display("FAIL reset_readies: aw/w/ar ready=%b, required 111",
                     {s_if.awready, s_if.wready, s_if.arready});
        end
        read_status(rv, d, rr);
        vec++;
        if (rv !== 1'b1 || d !== 32'h0000_0002 || rr !== 2'b00) begin
            err++;
            $display("FAIL reset_status: rvalid=%b rdata=%h rresp=%b, required 1 00000002 00", rv, d, rr);
        end
        vec++;
        if (tx !== 1'b1) begin
            err++;
            $display("FAIL reset_tx_idle: tx=%b, required 1", tx);
        end
    endtask

    task automatic test_frame_55();
        logic [7:0] bt = 8'h55;
        logic rv, ex;
        logic [31:0] d;
        logic [1:0] rr;
        int bad = 0;
        s_if.bready  = 1'b0;
        s_if.awvalid = 1'b1;
        s_if.wvalid  = 1'b1;
        s_if.wdata   = 32'h0000_0055;
        s_if.wmask   = 4'h1;
        tick();
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
        vec++;
        if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b00 || tx !== 1'b1) begin
            err++;
            $display("FAIL f55_bvalid: bvalid=%b bresp=%b tx=%b, required 1 00 1", s_if.bvalid, s_if.bresp, tx);
        end
        s_if.bready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) s_if.bready = 1'b0;
            ex = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : bt[k / 4 - 1];
            if (tx !== ex) bad++;
            if (k == 11) begin
                s_if.arvalid = 1'b0;
                vec++;
                if (s_if.rvalid !== 1'b1 || s_if.rdata !== 32'h0000_0006) begin
                    err++;
                    $display("FAIL f55_busy_status: rvalid=%b rdata=%h, required 1 00000006", s_if.rvalid, s_if.rdata);
                end
                s_if.rready = 1'b1;
            end
            if (k == 12) s_if.rready = 1'b0;
            if (k == 10) s_if.arvalid = 1'b1;
        end
        vec++;
        if (bad != 0) begin
            err++;
            $display("FAIL f55_waveform: %0d of 40 cycles wrong, required 0", bad);
        end
        tick();
        read_status(rv, d, rr);
        vec++;
        if (rv !== 1'b1 || d !== 32'h0000_0002 || tx !== 1'b1) begin
            err++;
            $display("FAIL f55_after_status: rvalid=%b rdata=%h tx=%b, required 1 00000002 1", rv, d, tx);
        end
    endtask

    task automatic test_split_aw_w();
        logic got, fok;
        logic [7:0] b;
        int t0;
        s_if.bready  = 1'b0;
        s_if.awvalid = 1'b1;
        tick();
        s_if.awvalid = 1'b0;
        vec++;
        if (s_if.awready !== 1'b0 || s_if.wready !== 1'b1 || s_if.bvalid !== 1'b0) begin
            err++;
            $display("FAIL split_aw_pending: awready=%b wready=%b bvalid=%b, required 0 1 0",
                     s_if.awready, s_if.wready, s_if.bvalid);
        end
        tick();
        tick();
        s_if.wvalid = 1'b1;
        s_if.wdata  = 32'h0000_00A3;
        s_if.wmask  = 4'h1;
        tick();
        s_if.wvalid = 1'b0;
        vec++;
        if (s_if.bvalid !== 1'b1 || tx !== 1'b1) begin
            err++;
            $display("FAIL split_commit: bvalid=%b tx=%b, required 1 1", s_if.bvalid, tx);
        end
        s_if.bready = 1'b1;
        tick();
        s_if.bready = 1'b0;
        vec++;
        if (s_if.bvalid !== 1'b0 || s_if.awready !== 1'b1 || tx !== 1'b0) begin
            err++;
            $display("FAIL split_b_done: bvalid=%b awready=%b tx=%b, required 0 1 0", s_if.bvalid, s_if.awready, tx);
        end
        rx_frame(got, b, t0, fok);
        vec++;
        if (!got || !fok || b !== 8'hA3) begin
            err++;
            $display("FAIL split_frame: got=%b framing=%b byte=%h, required 1 1 a3", got, fok, b);
        end
        repeat (D) tick();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                int n, wr_bad;
                logic ok, rv;
                logic [1:0] br, rr;
                logic [31:0] d;
                wr_bad = 0;
                for (int i = 0; i < 17; i++) begin
                    do_write(8'(i), 4'h1, 1'b1, n, ok, br);
                    if (!ok || n != 1) wr_bad++;
                end
                vec++;
                if (wr_bad != 0) begin
                    err++;
                    $display("FAIL b2b_first17: %0d writes not accepted at once, required 0", wr_bad);
                end
                read_status(rv, d, rr);
                vec++;
                if (rv !== 1'b1 || d !== 32'h0000_1005) begin
                    err++;
                    $display("FAIL b2b_full_status: rvalid=%b rdata=%h, required 1 00001005", rv, d);
                end
                s_if.awvalid = 1'b1;
                s_if.wvalid  = 1'b1;
                s_if.wdata   = 32'h0000_0011;
                s_if.wmask   = 4'h1;
                tick();
                s_if.awvalid = 1'b0;
                s_if.wvalid  = 1'b0;
                vec++;
                if (s_if.awready !== 1'b0 || s_if.wready !== 1'b0 || s_if.bvalid !== 1'b0) begin
                    err++;
                    $display("FAIL b2b_stall: awready=%b wready=%b bvalid=%b, required 0 0 0",
                             s_if.awready, s_if.wready, s_if.bvalid);
                end
                n = 0;
                while (s_if.bvalid !== 1'b1 && n < 100) begin
                    tick();
                    n++;
                end
                vec++;
                if (n != 6) begin
                    err++;
                    $display("FAIL b2b_stall_len: bvalid after %0d cycles, required 6", n);
                end
                tick();
            end
            begin
                logic got, fok;
                logic [7:0] b;
                int t0, t_prev;
                t_prev = 0;
                for (int k = 0; k < 18; k++) begin
                    rx_frame(got, b, t0, fok);
                    vec++;
                    if (!got || !fok || b !== 8'(k)) begin
                        err++;
                        $display("FAIL b2b_byte%0d: got=%b framing=%b byte=%h, required 1 1 %h", k, got, fok, b, 8'(k));
                    end
                    if (k > 0) begin
                        vec++;
                        if (t0 - t_prev != 10 * D) begin
                            err++;
                            $display("FAIL b2b_gap%0d: frame spacing %0d cycles, required %0d", k, t0 - t_prev, 10 * D);
                        end
                    end
                    t_prev = t0;
                end
            end
        join
        repeat (2 * D) tick();
    endtask

    task automatic test_mask_zero();
        int n, bad;
        logic ok, rv;
        logic [1:0] br, rr;
        logic [31:0] d;
        do_write(8'h77, 4'h0, 1'b1, n, ok, br);
        vec++;
        if (!ok || n != 1 || br !== 2'b00) begin
            err++;
            $display("FAIL mask0_resp: ok=%b cycles=%0d bresp=%b, required 1 1 00", ok, n, br);
        end
        read_status(rv, d, rr);
        vec++;
        if (rv !== 1'b1 || d !== 32'h0000_0002) begin
            err++;
            $display("FAIL mask0_status: rvalid=%b rdata=%h, required 1 00000002", rv, d);
        end
        bad = 0;
        repeat (50) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        vec++;
        if (bad != 0) begin
            err++;
            $display("FAIL mask0_tx_idle: tx low %0d cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, bad;
        logic ok, rv;
        logic [1:0] br, rr;
        logic [31:0] d;
        for (int i = 0; i < 6; i++) do_write(8'h00, 4'h1, 1'b1, n, ok, br);
        repeat (6) tick();
        vec++;
        if (tx !== 1'b0) begin
            err++;
            $display("FAIL rmid_in_frame: tx=%b during data bit 3, required 0", tx);
        end
        reset = 1'b0;
        #1;
        vec++;
        if (tx !== 1'b1 || s_if.bvalid !== 1'b0 || s_if.rvalid !== 1'b0) begin
            err++;
            $display("FAIL rmid_async: tx=%b bvalid=%b rvalid=%b, required 1 0 0", tx, s_if.bvalid, s_if.rvalid);
        end
        repeat (2) tick();
        reset = 1'b1;
        read_status(rv, d, rr);
        vec++;
        if (rv !== 1'b1 || d !== 32'h0000_0002) begin
            err++;
            $display("FAIL rmid_status: rvalid=%b rdata=%h, required 1 00000002", rv, d);
        end
        bad = 0;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        vec++;
        if (bad != 0) begin
            err++;
            $display("FAIL rmid_no_residual: tx low %0d cycles, required 0", bad);
        end
    endtask

    task automatic test_bready_hold();
        int n, bad;
        logic ok, rv;
        logic [1:0] br, rr;
        logic [31:0] d;
        do_write(8'h3C, 4'h1, 1'b0, n, ok, br);
        vec++;
        if (!ok || n != 1) begin
            err++;
            $display("FAIL bhold_first: ok=%b cycles=%0d, required 1 1", ok, n);
        end
        s_if.awvalid = 1'b1;
        s_if.wvalid  = 1'b1;
        s_if.wdata   = 32'h0000_005A;
        s_if.wmask   = 4'h1;
        bad = 0;
        repeat (10) begin
            tick();
            if (s_if.bvalid !== 1'b1 || s_if.awready !== 1'b0 || s_if.wready !== 1'b0) bad++;
        end
        vec++;
        if (bad != 0) begin
            err++;
            $display("FAIL bhold_blocked: %0d cycles wrong, required 0", bad);
        end
        s_if.bready = 1'b1;
        tick();
        s_if.bready = 1'b0;
        vec++;
        if (s_if.bvalid !== 1'b0 || s_if.awready !== 1'b1 || s_if.wready !== 1'b1) begin
            err++;
            $display("FAIL bhold_release: bvalid=%b awready=%b wready=%b, required 0 1 1",
                     s_if.bvalid, s_if.awready, s_if.wready);
        end
        tick();
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
        vec++;
        if (s_if.bvalid !== 1'b1) begin
            err++;
            $display("FAIL bhold_second: bvalid=%b, required 1", s_if.bvalid);
        end
        s_if.bready = 1'b1;
        tick();
        s_if.bready = 1'b0;
        read_status(rv, d, rr);
        vec++;
        if (rv !== 1'b1 || d !== 32'h0000_0104) begin
            err++;
            $display("FAIL bhold_status: rvalid=%b rdata=%h, required 1 00000104", rv, d);
        end
        repeat (100) tick();
    endtask

    initial begin
        s_if.awaddr  = '0;
        s_if.awvalid = 1'b0;
        s_if.wdata   = '0;
        s_if.wmask   = '0;
        s_if.wvalid  = 1'b0;
        s_if.bready  = 1'b0;
        s_if.araddr  = '0;
        s_if.arvalid = 1'b0;
        s_if.rready  = 1'b0;
        test_reset();
        test_frame_55();
        test_split_aw_w();
        test_back_to_back();
        test_mask_zero();
        test_reset_mid_frame();
        test_bready_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/uart_tx_lite.md
Name: uart_tx_lite

Overview:
- AXI4-Lite slave serial transmitter occupying the crossbar's 4-byte serial window (slave 0 port).
- Byte writes go into a TX FIFO. The FIFO drains through an 8N1 serializer onto a single `tx` line.
- Reads return a status word, so software can poll before writing or wait for drain.
- All valid/ready handshakes follow the team's `axi_lite_if` slave modport.

Parameters:
- DIVISOR, 16: clock cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 16: TX FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  sole clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion synchronous to clk.
- s  axi_lite_if.slave  bundle  AXI4-Lite slave.
  - Uses araddr/arvalid/arready/rdata[31:0]/rresp/rvalid/rready.
  - Uses awaddr/awvalid/awready/wdata[31:0]/wmask[3:0]/wvalid/wready/bresp/bvalid/bready.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (reset==0, takes effect immediately):
  - FIFO emptied, serializer to IDLE.
  - tx=1, bvalid=0, rvalid=0, rdata=0, bresp=0, rresp=0.
  - aw_pend=0, w_pend=0, so awready=wready=arready=1 after release.
  - A frame in progress when reset asserts is abandoned; tx returns high at once.
- Address bits are ignored; the crossbar already decodes the window.

Write channel:
- AW and W are accepted independently.
- awready = !aw_pend && !bvalid; wready = !w_pend && !bvalid.
- A handshake on either channel sets its pend flag; wdata[7:0] and wmask[0] are latched with W.
- Commit when both are pending (or handshaking this cycle) and FIFO not full:
  - Push byte if the latched wmask[0]==1; otherwise push nothing.
  - Clear both pend flags; bvalid=1 from the next cycle.
  - Commit covers AW and W in the same cycle or in either order.
- FIFO full: pend flags hold and bvalid stays low, i.e. back-pressure; no data is dropped.
- bvalid holds until bready; bresp always 0 (OKAY).

Read channel:
- arready = !rvalid.
- On AR handshake, at the next edge: rvalid=1 and rdata=status, sampled at the handshake cycle.
- rvalid and rdata hold until rready; rresp always 0.
- Status word:
  - bit0 full, bit1 empty, bit2 busy (serializer != IDLE).
  - bits[15:8] FIFO count, zero-extended.
  - all other bits 0.

FIFO:
- Circular, wrap-around read/write pointers, count width $clog2(FIFO_DEPTH)+1.
- Push and pop in the same cycle leave count unchanged.
- Full and empty are decided from registered count only; a same-cycle pop does not admit a push when full.

Serializer FSM (IDLE, START, DATA, STOP), baud counter counts DIVISOR-1 down to 0:
- IDLE:
  - If FIFO non-empty: pop into shift reg, go to START, tx<=0 at the same edge.
  - Otherwise tx stays 1.
- START: after DIVISOR cycles go to DATA; bit index=0; tx<=shift[0].
- DATA:
  - Every DIVISOR cycles shift LSB-first.
  - After bit 7's DIVISOR cycles go to STOP; tx<=1.
- STOP: after DIVISOR cycles:
  - If FIFO non-empty: pop, go to START, tx<=0 with no idle gap.
  - Otherwise go to IDLE.
- Frame length is exactly 10*DIVISOR cycles.
- tx is driven from a register; no glitches.

Latency:
- Commit at edge E: bvalid high after E; tx falls at edge E+1 if the serializer was IDLE.

Test Plan:
1. DIVISOR=4. After reset, read status -> rdata=0x00000002 one cycle after AR handshake, rresp=0; tx=1 throughout.
2. Write wdata=0x55, wmask=0x1, AW and W in the same cycle -> bvalid next cycle.
   - tx low one cycle later for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles (40-cycle frame).
   - busy=1 during the frame; status=0x00000002 afterwards.
3. AW alone, then W 3 cycles later (wdata=0xA3) -> awready drops after AW; commit on W handshake; bvalid the following cycle; frame carries 0xA3 LSB-first.
4. DEPTH=16, 18 back-to-back writes 0x00..0x11, bready=1:
   - First 17 accepted (one byte immediately in serializer); status count=16, full=1.
   - 18th stalls (bvalid low, awready/wready held low after capture) until the first frame ends, then completes.
   - All 18 bytes are emitted in order with no idle gaps.
5. Write with wmask=0x0 -> bvalid/bresp=0 returned; count stays 0; tx stays high.
6. Assert reset mid DATA bit 3 of a frame with 5 bytes queued -> tx=1 immediately; after release status=0x00000002; no residual frame is emitted.
7. bready held low 10 cycles after a write -> bvalid held; a second AW/W is not accepted until the B handshake completes.
